frv_mem_responder: RTL and testbench

- Responder (slave) end of the frv req/gnt/recv/ack memory interface that the core drives on imem_* and dmem_*.
- Word-addressed SRAM model with byte strobes, configurable response latency, and a bounded queue of outstanding transactions.
- Used as the on-chip memory behind the core, and as the reference responder in core-level benches.
- One instance per port: one for imem, one for dmem.

---
 rtl/frv_mem_responder_pkg.sv | 21 ++
 rtl/frv_mem_resp_fifo.sv | 63 ++++++
 rtl/frv_mem_responder.sv | 103 ++++++++++
 tb/tb_frv_mem_responder.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/frv_mem_responder_pkg.sv
// rtl/frv_mem_responder_pkg.sv - shared widths, response entry type and address check for the frv memory responder
package frv_mem_responder_pkg;

  localparam int FRV_MEM_RSP_W = 37;
  localparam int FRV_MEM_LAT_W = 4;

  typedef struct packed {
    logic [31:0]              rdata;
    logic                     error;
    logic [FRV_MEM_LAT_W-1:0] wait_cnt;
  } mem_rsp_t;

  // Offset is compared with one extra bit so base + size may reach 2^32.
  function automatic logic addr_fault(input logic [31:0] addr, input logic [31:0] base,
                                      input logic [32:0] bytes);
    logic [31:0] off;
    off = addr - base;
    return (addr[1:0] != 2'b00) || (addr < base) || ({1'b0, off} >= bytes);
  endfunction

endpackage

// File: rtl/frv_mem_resp_fifo.sv
// rtl/frv_mem_resp_fifo.sv - in-order response queue with per-entry latency countdown
module frv_mem_resp_fifo
  import frv_mem_responder_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        push,
  input  mem_rsp_t    push_data,
  input  logic        pop,
  output logic        full,
  output logic        head_ready,
  output logic [31:0] head_rdata,
  output logic        head_error
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  mem_rsp_t         entries [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full       = (count == CNT_W'(DEPTH));
  assign head_ready = (count != '0) && (entries[rd_ptr].wait_cnt == '0);
  assign head_rdata = entries[rd_ptr].rdata;
  assign head_error = entries[rd_ptr].error;
  assign do_push    = push && !full;
  assign do_pop     = pop && head_ready;

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
    end else begin
      // Every entry counts down, so a queued response is due as soon as it reaches the head.
      for (int i = 0; i < DEPTH; i++) begin
        if (entries[i].wait_cnt != '0) entries[i].wait_cnt <= entries[i].wait_cnt - 1'b1;
      end
      if (do_push) begin
        entries[wr_ptr] <= push_data;
        wr_ptr          <= ptr_inc(wr_ptr);
      end
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/frv_mem_responder.sv
// rtl/frv_mem_responder.sv - word-addressed SRAM responder for the frv req/gnt/recv/ack memory port
module frv_mem_responder
  import frv_mem_responder_pkg::*;
#(
  parameter logic [31:0] MEM_BASE        = 32'h8000_0000,
  parameter int          MEM_WORDS       = 1024,
  parameter int          LATENCY         = 1,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        stall,
  input  logic        mem_req,
  input  logic        mem_wen,
  input  logic [3:0]  mem_strb,
  input  logic [31:0] mem_wdata,
  input  logic [31:0] mem_addr,
  output logic        mem_gnt,
  output logic        mem_recv,
  input  logic        mem_ack,
  output logic        mem_error,
  output logic [31:0] mem_rdata
);

  localparam int          IDX_W     = $clog2(MEM_WORDS);
  localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) << 2;

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("frv_mem_responder: LATENCY must be in 1..15");
  end
  if (MEM_BASE[1:0] != 2'b00) begin : g_bad_base
    $error("frv_mem_responder: MEM_BASE must be word aligned");
  end
  if (MEM_WORDS < 2 || (MEM_WORDS & (MEM_WORDS - 1)) != 0) begin : g_bad_words
    $error("frv_mem_responder: MEM_WORDS must be a power of 2");
  end
  if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 4) begin : g_bad_depth
    $error("frv_mem_responder: MAX_OUTSTANDING must be in 1..4");
  end

  logic [31:0]      mem [MEM_WORDS];
  logic [IDX_W-1:0] idx;
  logic             addr_err;
  logic             accept;
  logic             fifo_full;
  logic             head_ready;
  logic [31:0]      head_rdata;
  logic             head_error;
  logic [31:0]      rdata_hold;
  logic             error_hold;
  mem_rsp_t         push_data;

  // gnt depends only on stall and the registered fill level, never on req or ack.
  assign mem_gnt  = !stall && !fifo_full;
  assign accept   = mem_req && mem_gnt;
  assign addr_err = addr_fault(mem_addr, MEM_BASE, MEM_BYTES);
  assign idx      = IDX_W'((mem_addr - MEM_BASE) >> 2);

  always_comb begin
    push_data          = '0;
    push_data.error    = addr_err;
    push_data.wait_cnt = FRV_MEM_LAT_W'(LATENCY - 1);
    if (!addr_err && !mem_wen) push_data.rdata = mem[idx];
  end

  always_ff @(posedge g_clk) begin
    if (accept && mem_wen && !addr_err) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_strb[i]) mem[idx][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
    end
  end

  frv_mem_resp_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_fifo (
    .g_clk      (g_clk),
    .g_resetn   (g_resetn),
    .push       (accept),
    .push_data  (push_data),
    .pop        (mem_recv && mem_ack),
    .full       (fifo_full),
    .head_ready (head_ready),
    .head_rdata (head_rdata),
    .head_error (head_error)
  );

  // Last delivered response is replayed on rdata/error while recv is low.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      rdata_hold <= '0;
      error_hold <= 1'b0;
    end else if (head_ready) begin
      rdata_hold <= head_rdata;
      error_hold <= head_error;
    end
  end

  assign mem_recv  = head_ready;
  assign mem_rdata = head_ready ? head_rdata : rdata_hold;
  assign mem_error = head_ready ? head_error : error_hold;

endmodule

// File: tb/tb_frv_mem_responder.sv
// tb/tb_frv_mem_responder.sv - self-checking bench for frv_mem_responder
module tb_frv_mem_responder;

  typedef struct {
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        g_resetn;
  logic        stall, req, wen, ack, gnt, recv, err;
  logic [3:0]  strb;
  logic [31:0] wdata, addr, rdata;
  logic        l3_stall, l3_req, l3_wen, l3_ack, l3_gnt, l3_recv, l3_err;
  logic [3:0]  l3_strb;
  logic [31:0] l3_wdata, l3_addr, l3_rdata;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  vec_t tbl[17];

  always #5 clk = ~clk;

  frv_mem_responder #(.LATENCY(1), .MAX_OUTSTANDING(2)) u_dut (
    .g_clk(clk), .g_resetn(g_resetn), .stall(stall), .mem_req(req), .mem_wen(wen),
    .mem_strb(strb), .mem_wdata(wdata), .mem_addr(addr), .mem_gnt(gnt), .mem_recv(recv),
    .mem_ack(ack), .mem_error(err), .mem_rdata(rdata)
  );

  frv_mem_responder #(.LATENCY(3), .MAX_OUTSTANDING(2)) u_dut3 (
    .g_clk(clk), .g_resetn(g_resetn), .stall(l3_stall), .mem_req(l3_req), .mem_wen(l3_wen),
    .mem_strb(l3_strb), .mem_wdata(l3_wdata), .mem_addr(l3_addr), .mem_gnt(l3_gnt),
    .mem_recv(l3_recv), .mem_ack(l3_ack), .mem_error(l3_err), .mem_rdata(l3_rdata)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic sb_push(input logic [31:0] r, input logic e);
    exp_t x;
    x.rdata = r;
    x.err   = e;
    sb.push_back(x);
  endtask

  // Scoreboard side: every handshaken response is compared against the oldest expectation.
  always @(negedge clk) begin
    if (g_resetn === 1'b1 && recv === 1'b1 && ack === 1'b1) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_recv", 32'd1, 32'd0);
      end else begin
        exp_t x;
        x = sb.pop_front();
        chk("sb_rdata", rdata, x.rdata);
        chk("sb_error", {31'd0, err}, {31'd0, x.err});
      end
    end
  end

  task automatic do_req(input vec_t v);
    int n = 0;
    @(posedge clk); #1;
    req = 1'b1; wen = v.wen; addr = v.addr; wdata = v.wdata; strb = v.strb;
    @(negedge clk);
    while (gnt !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (gnt !== 1'b1) chk("req_gnt_timeout", {31'd0, gnt}, 32'd1);
    else sb_push(v.exp_rdata, v.exp_err);
    @(posedge clk); #1;
    req = 1'b0; wen = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", sb.size(), 32'd0);
    sb.delete();
  endtask

  task automatic set_vec(input int i, input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic [31:0] er, input logic ee);
    tbl[i].wen = w; tbl[i].addr = a; tbl[i].wdata = d; tbl[i].strb = s;
    tbl[i].exp_rdata = er; tbl[i].exp_err = ee;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    set_vec(0,  1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0,         0);
    set_vec(1,  0, 32'h8000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF, 0);
    set_vec(2,  1, 32'h8000_0004, 32'h1122_3344, 4'hF, 32'h0,         0);
    set_vec(3,  1, 32'h8000_0004, 32'h0000_00AA, 4'h1, 32'h0,         0);
    set_vec(4,  0, 32'h8000_0004, 32'h0,         4'h0, 32'h1122_33AA, 0);
    set_vec(5,  0, 32'h0000_0000, 32'h0,         4'h0, 32'h0,         1);
    set_vec(6,  0, 32'h8000_0002, 32'h0,         4'h0, 32'h0,         1);
    set_vec(7,  1, 32'h8000_0011, 32'hFFFF_FFFF, 4'hF, 32'h0,         1);
    set_vec(8,  0, 32'h8000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF, 0);
    set_vec(9,  1, 32'h8000_0000, 32'h5A5A_5A5A, 4'hF, 32'h0,         0);
    set_vec(10, 1, 32'h8000_0FFC, 32'hA5A5_A5A5, 4'hF, 32'h0,         0);
    set_vec(11, 1, 32'h8000_0FFC, 32'h1234_5678, 4'hA, 32'h0,         0);
    set_vec(12, 0, 32'h8000_0FFC, 32'h0,         4'h0, 32'h12A5_56A5, 0);
    set_vec(13, 1, 32'h8000_1000, 32'h0123_4567, 4'hF, 32'h0,         1);
    set_vec(14, 1, 32'h7FFF_FFFC, 32'h0123_4567, 4'hF, 32'h0,         1);
    set_vec(15, 0, 32'h8000_0000, 32'h0,         4'h0, 32'h5A5A_5A5A, 0);
    set_vec(16, 0, 32'h8000_0FFC, 32'h0,         4'h0, 32'h12A5_56A5, 0);

    g_resetn = 1'b0;
    stall = 0; req = 0; wen = 0; strb = 0; wdata = 0; addr = 0; ack = 1;
    l3_stall = 0; l3_req = 0; l3_wen = 0; l3_strb = 0; l3_wdata = 0; l3_addr = 0; l3_ack = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_recv", {31'd0, recv}, 32'd0);
    chk("reset_error", {31'd0, err}, 32'd0);
    chk("reset_rdata", rdata, 32'd0);
    @(posedge clk); #1;
    g_resetn = 1'b1;
    @(negedge clk);
    chk("idle_gnt", {31'd0, gnt}, 32'd1);
    stall = 1'b1;
    #1 chk("stall_gnt", {31'd0, gnt}, 32'd0);
    stall = 1'b0;

    for (int i = 0; i < 17; i++) do_req(tbl[i]);
    drain();

    // LATENCY=1: recv in the cycle right after the accept edge.
    @(posedge clk); #1;
    req = 1; wen = 0; addr = 32'h8000_0010;
    @(negedge clk);
    chk("lat1_gnt", {31'd0, gnt}, 32'd1);
    sb_push(32'hDEAD_BEEF, 1'b0);
    @(posedge clk); #1;
    req = 0;
    @(negedge clk);
    chk("lat1_recv", {31'd0, recv}, 32'd1);
    drain();

    // Back-pressure with a full queue.
    @(posedge clk); #1;
    ack = 0; req = 1; wen = 0; addr = 32'h8000_0010;
    @(negedge clk);
    chk("bp_gnt1", {31'd0, gnt}, 32'd1);
    sb_push(32'hDEAD_BEEF, 1'b0);
    @(posedge clk); #1;
    addr = 32'h8000_0004;
    @(negedge clk);
    chk("bp_gnt2", {31'd0, gnt}, 32'd1);
    sb_push(32'h1122_33AA, 1'b0);
    @(posedge clk); #1;
    addr = 32'h8000_0FFC;
    @(negedge clk);
    chk("bp_gnt3_low", {31'd0, gnt}, 32'd0);
    chk("bp_head_recv", {31'd0, recv}, 32'd1);
    chk("bp_head_rdata", rdata, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    ack = 1;
    @(negedge clk);
    chk("bp_gnt_full_ack", {31'd0, gnt}, 32'd0);
    @(posedge clk); #1;
    ack = 0;
    @(negedge clk);
    chk("bp_gnt_rise", {31'd0, gnt}, 32'd1);
    sb_push(32'h12A5_56A5, 1'b0);
    @(posedge clk); #1;
    req = 0; ack = 1;
    drain();

    // LATENCY=3 instance: timing and hold while ack is low.
    @(posedge clk); #1;
    l3_req = 1; l3_wen = 1; l3_addr = 32'h8000_0020; l3_wdata = 32'hCAFE_F00D; l3_strb = 4'hF;
    @(negedge clk);
    chk("l3_wr_gnt", {31'd0, l3_gnt}, 32'd1);
    @(posedge clk); #1;
    l3_req = 0; l3_wen = 0;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (l3_recv === 1'b1) break;
    end
    chk("l3_wr_lat", n, 32'd3);
    chk("l3_wr_rdata", l3_rdata, 32'd0);
    chk("l3_wr_error", {31'd0, l3_err}, 32'd0);
    @(posedge clk); #1;
    l3_ack = 0; l3_req = 1; l3_addr = 32'h8000_0020;
    @(negedge clk);
    chk("l3_rd_gnt", {31'd0, l3_gnt}, 32'd1);
    @(posedge clk); #1;
    l3_req = 0;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (l3_recv === 1'b1) break;
    end
    chk("l3_rd_lat", n, 32'd3);
    chk("l3_rd_rdata", l3_rdata, 32'hCAFE_F00D);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("l3_hold_recv", {31'd0, l3_recv}, 32'd1);
      chk("l3_hold_rdata", l3_rdata, 32'hCAFE_F00D);
      chk("l3_hold_error", {31'd0, l3_err}, 32'd0);
    end
    @(posedge clk); #1;
    l3_ack = 1;
    @(negedge clk);
    chk("l3_ack_recv", {31'd0, l3_recv}, 32'd1);
    @(posedge clk); #1;
    l3_ack = 0;
    @(negedge clk);
    chk("l3_pop_recv", {31'd0, l3_recv}, 32'd0);
    chk("l3_rdata_held", l3_rdata, 32'hCAFE_F00D);

    // Asynchronous reset with two responses pending.
    @(posedge clk); #1;
    ack = 0; req = 1; wen = 0; addr = 32'h8000_0010;
    @(posedge clk); #1;
    addr = 32'h8000_0004;
    @(posedge clk); #1;
    req = 0;
    @(negedge clk);
    chk("rst_pre_recv", {31'd0, recv}, 32'd1);
    chk("rst_pre_full", {31'd0, gnt}, 32'd0);
    #2 g_resetn = 1'b0;
    #1;
    chk("rst_recv_async", {31'd0, recv}, 32'd0);
    chk("rst_rdata_async", rdata, 32'd0);
    @(posedge clk);
    @(posedge clk); #1;
    g_resetn = 1'b1;
    @(negedge clk);
    chk("rst_gnt", {31'd0, gnt}, 32'd1);
    chk("rst_recv", {31'd0, recv}, 32'd0);
    ack = 1;
    do_req(tbl[4]);
    do_req(tbl[1]);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
